acq_reader: RTL and testbench
=============================

# acq_reader

Reads captured acquisition lines back out of external RAM and serialises them as a byte stream for the host link (USB FIFO bridge). It is the read-side counterpart of the acquisition writer. It walks the same `{line, word}` address map, issues fixed-latency RAM reads, buffers returned words in a small FIFO and emits each 16-bit word as two bytes under valid/ready flow control.

## Interface

**Parameters**
- `RAM_DATA_W`, 16: RAM word width. Fixed at 16 because each word is split into 2 bytes.
- `RAM_ADDR_W`, 19: RAM address width. Must equal `ACQ_LINES_W + WORD_CNT_W`.
- `ACQ_LINES_MAX`, 32: maximum lines per readout.
- `ACQ_LINES_W`, `$clog2(ACQ_LINES_MAX)`: width of the lines field.
- `ACQ_WORDS_PER_LINE`, 16384: words per line. Power of 2. `WORD_CNT_W = $clog2` of this value.
- `RAM_RD_LAT`, 2: cycles from `ram_ren` to valid `ram_rdata`. Range 1..4.
- `FIFO_DEPTH`, 4: word buffer depth. Power of 2, and `>= RAM_RD_LAT + 1`.

**Ports**
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rd_start`, in, 1: start pulse. Sampled only in IDLE.
- `rd_abort`, in, 1: abort the readout in progress.
- `rd_lines`, in, `ACQ_LINES_W`: index of the last line to read. Lines read = `rd_lines+1`.
- `rd_busy`, out, 1: readout in progress.
- `rd_done`, out, 1: level signal. Set when a readout completes; cleared by the next accepted `rd_start`.
- `ram_raddr`, out, `RAM_ADDR_W`: read address, formed as `{line_cnt, word_cnt}`.
- `ram_ren`, out, 1: read strobe, one word per cycle it is high.
- `ram_rdata`, in, `RAM_DATA_W`: read data, valid `RAM_RD_LAT` cycles after `ram_ren`.
- `tx_data`, out, 8: byte out. MSB byte first, then LSB byte.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: sink accepts the byte. A transfer occurs when `tx_valid & tx_ready`.

## Operation

**State machine: IDLE, READ, DRAIN, DONE**
- IDLE
  - On `rd_start`: latch `rd_lines`, clear `line_cnt`/`word_cnt`, set `rd_busy=1`, set `rd_done=0`, go to READ.
- READ
  - Issue `ram_ren` whenever `inflight + fifo_count < FIFO_DEPTH` (credit rule).
  - After each issue, `word_cnt` increments.
  - At `word_cnt == ACQ_WORDS_PER_LINE-1`: `word_cnt` wraps to 0 and `line_cnt` increments.
  - Issuing the last word of the last line (`line_cnt == rd_lines`) moves the FSM to DRAIN.
- DRAIN
  - No new reads.
  - Waits until in-flight reads are 0, the FIFO is empty and the serialiser is idle, then goes to DONE.
- DONE
  - For one cycle: `rd_busy=0`, `rd_done=1`, then go to IDLE.

**Datapath**
- Read-return tracking: a `RAM_RD_LAT`-deep valid shift register. `inflight` is the count of ones in it.
- Returned data is written to the FIFO unconditionally. The credit rule guarantees the FIFO never overflows.
- Serialiser: pops a word, presents the high byte, then the low byte. It pops the next word in the same cycle the low byte transfers, so there is no bubble.

**Boundary behaviour**
- `rd_lines=0`: exactly one line is read.
- `rd_lines >= ACQ_LINES_MAX`: accepted as given. The address wraps modulo `2^ACQ_LINES_W`.
- `rd_start` outside IDLE: ignored.
- `rd_abort` in READ or DRAIN:
  - Next cycle: FSM is in IDLE, the FIFO is flushed, in-flight returns are discarded, `tx_valid=0`, `rd_busy=0`, `rd_done` stays 0.
  - `tx_valid` may drop without a handshake on abort only. This is the sole exception to the stability rule.
- `rd_abort` and `rd_start` together in IDLE: abort wins and the start is ignored.
- Reset mid-operation: every output returns immediately to its reset value. Data in flight is lost.

## Timing

- Reset values: `rd_busy=0`, `rd_done=0`, `ram_raddr=0`, `ram_ren=0`, `tx_data=0`, `tx_valid=0`.
- All outputs are registered.
- Start latency:
  - `rd_start` at cycle 0 gives `ram_ren=1` with address 0 at cycle 1.
  - First `tx_valid` appears at cycle `1+RAM_RD_LAT+1`.
- Stability: once `tx_valid=1`, `tx_data` is held until the transfer (except on abort).
- Throughput: one byte per cycle while `tx_ready=1`, i.e. one RAM read every 2 cycles at steady state.
- With `tx_ready=0`: reads stop after at most `FIFO_DEPTH` outstanding words, with no loss.
- `rd_done` rises exactly 1 cycle after the final byte transfer (the DONE cycle is included).
- Ordering: byte count per readout = `2 * ACQ_WORDS_PER_LINE * (rd_lines+1)`. Addresses are strictly ascending.

## Test plan

All scenarios use `ACQ_WORDS_PER_LINE=8`, `ACQ_LINES_MAX=4`, `RAM_ADDR_W=5`, `RAM_RD_LAT=2`, `FIFO_DEPTH=4`, and a RAM model where `data = 0xA000 | addr`.

1. `rd_lines=0`, `tx_ready=1` → bytes `A0,00,A0,01,…,A0,07` (16 bytes). First `tx_valid` 4 cycles after `rd_start`. `rd_done` set 1 cycle after the last byte; `rd_busy` low at the same time.
2. `rd_lines=3`, `tx_ready=1` → 64 bytes, addresses 0..31 in order. After address 7, the next read is 8 (`line_cnt=1`, `word_cnt=0`).
3. `rd_lines=1`, `tx_ready` toggling randomly 30% high → same 32-byte sequence as with `tx_ready=1`. `tx_data` stable while `tx_valid & !tx_ready`. Never more than 4 words outstanding plus buffered.
4. `rd_lines=3`, `tx_ready=0` for 20 cycles then 1 → exactly 4 `ram_ren` pulses while stalled, then the full 64 bytes with no gaps or duplicates.
5. `rd_lines=3`, `rd_abort` after the 10th byte → next cycle `tx_valid=0`, `rd_busy=0`, `rd_done=0`, no further `ram_ren`. A fresh `rd_start` then restarts from address 0.
6. `rst` pulsed mid-READ; `rd_start` asserted while busy → reset forces all outputs to 0. The `rd_start` while busy is ignored and the byte stream is unchanged.

Source files
------------

// File: rtl/acq_reader.sv
// Reads acquisition lines back from external RAM and streams each 16-bit word
// to the host link as two bytes (MSB first) under valid/ready flow control.
module acq_reader #(
  parameter int RAM_DATA_W         = 16,
  parameter int RAM_ADDR_W         = 19,
  parameter int ACQ_LINES_MAX      = 32,
  parameter int ACQ_LINES_W        = $clog2(ACQ_LINES_MAX),
  parameter int ACQ_WORDS_PER_LINE = 16384,
  parameter int RAM_RD_LAT         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_start,
  input  logic                   rd_abort,
  input  logic [ACQ_LINES_W-1:0] rd_lines,
  output logic                   rd_busy,
  output logic                   rd_done,
  output logic [RAM_ADDR_W-1:0]  ram_raddr,
  output logic                   ram_ren,
  input  logic [RAM_DATA_W-1:0]  ram_rdata,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  localparam int WORD_CNT_W = $clog2(ACQ_WORDS_PER_LINE);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ACQ_LINES_W-1:0] rd_lines_q, rd_lines_d;
  logic [ACQ_LINES_W-1:0] line_cnt_q, line_cnt_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [RAM_ADDR_W-1:0]  ram_raddr_q, ram_raddr_d;
  logic                   ram_ren_q, ram_ren_d;
  logic [RAM_RD_LAT-1:0]  vld_q, vld_d;
  logic [RAM_DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [RAM_DATA_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   tx_phase_q, tx_phase_d;
  logic                   rd_busy_q, rd_busy_d;
  logic                   rd_done_q, rd_done_d;

  logic                   start_ok, abort_ok, xfer, pop, push;
  logic                   issue, issue_last, drained;
  logic [RAM_RD_LAT-1:0]  vld_next;
  logic [CNT_W-1:0]       inflight_next, count_next;
  logic [ACQ_LINES_W-1:0] base_line, last_line;
  logic [WORD_CNT_W-1:0]  base_word;
  logic [RAM_DATA_W-1:0]  head;

  // The word being serialised stays in the FIFO until its low byte leaves,
  // so FIFO occupancy plus in-flight reads bounds all storage to FIFO_DEPTH.
  always_comb begin
    start_ok      = (state_q == S_IDLE) && rd_start && !rd_abort;
    abort_ok      = rd_abort && ((state_q == S_READ) || (state_q == S_DRAIN));
    xfer          = tx_valid_q && tx_ready;
    pop           = xfer && tx_phase_q;
    push          = vld_q[RAM_RD_LAT-1];
    vld_next      = RAM_RD_LAT'({vld_q, ram_ren_q});
    inflight_next = '0;
    for (int i = 0; i < RAM_RD_LAT; i++) begin
      inflight_next = inflight_next + CNT_W'(vld_next[i]);
    end
    count_next    = count_q + CNT_W'(push) - CNT_W'(pop);
    base_line     = start_ok ? '0 : line_cnt_q;
    base_word     = start_ok ? '0 : word_cnt_q;
    last_line     = start_ok ? rd_lines : rd_lines_q;
    issue         = start_ok ||
                    ((state_q == S_READ) && !rd_abort &&
                     ((inflight_next + count_next) < CNT_W'(FIFO_DEPTH)));
    issue_last    = issue && (&base_word) && (base_line == last_line);
    drained       = (vld_next == '0) && (count_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = issue_last ? S_DRAIN : S_READ;
      S_READ: begin
        if (rd_abort)        state_d = S_IDLE;
        else if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_abort)     state_d = S_IDLE;
        else if (drained) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    if (state_d == S_DONE) begin
      rd_done_d = 1'b1;
    end else if (start_ok) begin
      rd_done_d = 1'b0;
    end else begin
      rd_done_d = rd_done_q;
    end
  end

  always_comb begin
    rd_lines_d  = start_ok ? rd_lines : rd_lines_q;
    line_cnt_d  = line_cnt_q;
    word_cnt_d  = word_cnt_q;
    ram_raddr_d = ram_raddr_q;
    ram_ren_d   = issue;
    vld_d       = vld_next;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_next;
    tx_data_d   = tx_data_q;
    tx_phase_d  = tx_phase_q;
    tx_valid_d  = (count_next != '0);
    head        = (count_q > CNT_W'(pop)) ? mem_q[rd_ptr_q + PTR_W'(pop)] : ram_rdata;

    if (issue) begin
      ram_raddr_d = {base_line, base_word};
      word_cnt_d  = base_word + WORD_CNT_W'(1);
      line_cnt_d  = base_line + ACQ_LINES_W'(&base_word);
    end

    if (push) begin
      mem_d[wr_ptr_q] = ram_rdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Next word comes from the FIFO, or straight off the RAM bus when empty.
    if (tx_valid_q && !xfer) begin
      tx_data_d = tx_data_q;
    end else if (xfer && !tx_phase_q) begin
      tx_data_d  = mem_q[rd_ptr_q][7:0];
      tx_phase_d = 1'b1;
    end else if (count_next != '0) begin
      tx_data_d  = head[RAM_DATA_W-1 -: 8];
      tx_phase_d = 1'b0;
    end

    if (abort_ok) begin
      ram_ren_d  = 1'b0;
      vld_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tx_valid_d = 1'b0;
      tx_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lines_q  <= '0;
      line_cnt_q  <= '0;
      word_cnt_q  <= '0;
      ram_raddr_q <= '0;
      ram_ren_q   <= 1'b0;
      vld_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_phase_q  <= 1'b0;
      rd_busy_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      rd_lines_q  <= rd_lines_d;
      line_cnt_q  <= line_cnt_d;
      word_cnt_q  <= word_cnt_d;
      ram_raddr_q <= ram_raddr_d;
      ram_ren_q   <= ram_ren_d;
      vld_q       <= vld_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_phase_q  <= tx_phase_d;
      rd_busy_q   <= rd_busy_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign rd_busy   = rd_busy_q;
  assign rd_done   = rd_done_q;
  assign ram_raddr = ram_raddr_q;
  assign ram_ren   = ram_ren_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_acq_reader.sv
// Testbench for acq_reader: fixed-latency RAM model returning 0xA000|addr and a
// reference byte stream derived from the address order of a readout.
module tb_acq_reader;

  localparam int LINES_MAX = 4;
  localparam int LINES_W   = $clog2(LINES_MAX);
  localparam int WORDS     = 8;
  localparam int ADDR_W    = 5;
  localparam int LAT       = 2;
  localparam int DEPTH     = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rd_start = 1'b0;
  logic               rd_abort = 1'b0;
  logic               tx_ready = 1'b0;
  logic [LINES_W-1:0] rd_lines = '0;
  logic               rd_busy, rd_done, ram_ren, tx_valid;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [15:0]        ram_rdata, ram_pipe0, ram_pipe1;
  logic [7:0]         tx_data;
  int                 checks = 0;
  int                 failures = 0;
  int                 cyc = 0;

  always #5 clk = ~clk;

  acq_reader #(
    .RAM_DATA_W(16), .RAM_ADDR_W(ADDR_W), .ACQ_LINES_MAX(LINES_MAX),
    .ACQ_LINES_W(LINES_W), .ACQ_WORDS_PER_LINE(WORDS), .RAM_RD_LAT(LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_abort(rd_abort),
    .rd_lines(rd_lines), .rd_busy(rd_busy), .rd_done(rd_done),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // RAM returns 0xA000|addr two cycles after a strobe, garbage otherwise
  always @(posedge clk) begin
    ram_pipe0 <= ram_ren ? (16'hA000 | 16'(ram_raddr)) : 16'hDEAD;
    ram_pipe1 <= ram_pipe0;
  end
  assign ram_rdata = ram_pipe1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Byte idx of a readout: word idx/2 lives at address idx/2, MSB byte first
  function automatic logic [7:0] exp_byte(input int idx);
    logic [15:0] w;
    w = 16'hA000 | 16'(idx / 2);
    return (idx % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic applyStimulus(input int lines, input int ready_pct, input int stall,
                               input int abort_at, input bit poke_start);
    int n_bytes, bytes, words_done, rens, stall_rens, exp_addr;
    int first_valid, first_xfer, last_xfer, abort_cyc, post_rens;
    bit hold, finished;
    logic [7:0] held;
    n_bytes = 2 * WORDS * (lines + 1);
    bytes = 0; words_done = 0; rens = 0; stall_rens = 0; exp_addr = 0;
    first_valid = -1; first_xfer = -1; last_xfer = -1; abort_cyc = -10;
    hold = 1'b0; finished = 1'b0; held = '0;
    rd_lines = LINES_W'(lines);
    rd_start = 1'b1;
    tx_ready = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      rd_start = poke_start && (k == 6);
      if (k == abort_cyc + 1) begin
        rd_abort = 1'b0;
        checkOutput("abort_valid", tx_valid, 0);
        checkOutput("abort_busy", rd_busy, 0);
        checkOutput("abort_done", rd_done, 0);
        finished = 1'b1;
        break;
      end
      rd_abort = (k == abort_cyc);
      if (k == 1) begin
        checkOutput("start_ren", ram_ren, 1);
        checkOutput("start_addr", ram_raddr, 0);
        checkOutput("start_busy", rd_busy, 1);
        checkOutput("start_done_clr", rd_done, 0);
      end
      if (ram_ren) begin
        checkOutput("ren_in_range", exp_addr < n_bytes / 2, 1);
        checkOutput("ren_addr", 32'(ram_raddr), 32'(exp_addr));
        exp_addr++;
        rens++;
        if (k <= stall) stall_rens++;
      end
      checkOutput("credit", (rens - words_done) <= DEPTH, 1);
      if (k == abort_cyc || k <= stall) tx_ready = 1'b0;
      else tx_ready = ($urandom_range(0, 99) < ready_pct);
      if (hold) begin
        checkOutput("stable_valid", tx_valid, 1);
        checkOutput("stable_data", tx_data, held);
      end
      hold = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && first_valid < 0) first_valid = k;
      if (tx_valid && tx_ready) begin
        checkOutput("byte", tx_data, exp_byte(bytes));
        if (first_xfer < 0) first_xfer = k;
        last_xfer = k;
        bytes++;
        if (bytes % 2 == 0) words_done++;
        if (abort_at > 0 && bytes == abort_at) abort_cyc = k + 1;
      end
      if (k >= 2 && rd_done) begin
        checkOutput("done_latency", k, last_xfer + 1);
        checkOutput("done_busy", rd_busy, 0);
        checkOutput("byte_count", bytes, n_bytes);
        checkOutput("addr_count", exp_addr, n_bytes / 2);
        checkOutput("first_valid", first_valid, 1 + LAT + 1);
        if (ready_pct == 100) checkOutput("no_gap", last_xfer - first_xfer + 1, bytes);
        if (stall > 0) checkOutput("stall_rens", stall_rens, DEPTH);
        finished = 1'b1;
        break;
      end
      if (!rd_done) checkOutput("busy", rd_busy, 1);
    end
    rd_start = 1'b0;
    rd_abort = 1'b0;
    if (!finished) checkOutput("timeout", 1, 0);
    if (abort_at > 0) begin
      post_rens = 0;
      for (int j = 0; j < 8; j++) begin
        if (ram_ren) post_rens++;
        tick();
      end
      checkOutput("abort_no_ren", post_rens, 0);
    end else begin
      tick();
      checkOutput("done_level", rd_done, 1);
      checkOutput("idle_busy", rd_busy, 0);
    end
  endtask

  initial begin
    tick();
    tick();
    checkOutput("reset_outputs", {rd_busy, rd_done, ram_ren, tx_valid, tx_data, ram_raddr}, 0);
    rst = 1'b0;
    tick();

    applyStimulus(0, 100, 0, 0, 1'b0);
    applyStimulus(3, 100, 0, 0, 1'b0);
    applyStimulus(1, 30, 0, 0, 1'b0);
    applyStimulus(3, 100, 20, 0, 1'b0);
    applyStimulus(3, 100, 0, 10, 1'b0);
    applyStimulus(3, 100, 0, 0, 1'b0);

    rd_start = 1'b1;
    rd_abort = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_abort = 1'b0;
    for (int j = 0; j < 5; j++) begin
      checkOutput("abort_wins_ren", ram_ren, 0);
      checkOutput("abort_wins_busy", rd_busy, 0);
      tick();
    end
    checkOutput("abort_wins_done_kept", rd_done, 1);

    rd_lines = LINES_W'(3);
    rd_start = 1'b1;
    tx_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    checkOutput("pre_reset_busy", rd_busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_outputs", {rd_busy, rd_done, ram_ren, tx_valid, tx_data, ram_raddr}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1, 50, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
